// File: rtl/acx_ethernet_rx_rate_monitor.sv
// Passive RX stream monitor: windowed packet, payload-byte and wire-byte counts with
// runt/error tallies and sticky framing detection. Never touches the data path.
module acx_ethernet_rx_rate_monitor #(
    parameter int DATA_WIDTH      = 256,
    parameter int IPG_LENGTH      = 12,
    parameter int FCS_LENGTH      = 4,
    parameter int PREAMBLE_LENGTH = 8,
    parameter int RUNT_LENGTH     = 60,
    parameter int CNT_WIDTH       = 40,
    localparam int BYTE_WIDTH     = DATA_WIDTH / 8,
    localparam int MOD_WIDTH      = $clog2(BYTE_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic                 in_ready,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [MOD_WIDTH-1:0] in_mod,
    input  logic                 in_err,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [31:0]          window_cycles,
    output logic                 win_done,
    output logic [31:0]          win_pkts,
    output logic [CNT_WIDTH-1:0] win_bytes,
    output logic [CNT_WIDTH-1:0] win_wire_bytes,
    output logic [15:0]          win_runts,
    output logic [15:0]          win_err_pkts,
    output logic                 framing_err,
    output logic                 in_pkt
);

    localparam int BW1 = MOD_WIDTH + 1;
    localparam int SUM_W = ((CNT_WIDTH > 18) ? CNT_WIDTH : 18) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});
    localparam logic [17:0] OVERHEAD = 18'(FCS_LENGTH + PREAMBLE_LENGTH + IPG_LENGTH);

    typedef enum logic {IDLE, IN_PKT} state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [17:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > CNT_MAX) s = CNT_MAX;
        return s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat_len(input logic [15:0] a, input logic [BW1-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t                 state, state_next;
    logic [15:0]            pkt_len, len_next, cur_len;
    logic [BW1-1:0]         beat_bytes;
    logic                   accepted, framing_set;
    logic [17:0]            byte_inc, wire_inc;
    logic [1:0]             pkt_inc, runt_inc, err_inc;
    logic [31:0]            win_cnt;
    logic                   win_active, win_final;
    logic [31:0]            acc_pkts;
    logic [CNT_WIDTH-1:0]   acc_bytes, acc_wire;
    logic [15:0]            acc_runts, acc_errs;
    logic [31:0]            pkts_next;
    logic [CNT_WIDTH-1:0]   bytes_next, wire_next;
    logic [15:0]            runts_next, errs_next;

    assign accepted   = in_valid & in_ready;
    assign beat_bytes = (!in_eop || in_mod == '0) ? BW1'(BYTE_WIDTH) : {1'b0, in_mod};
    assign win_active = enable && (window_cycles != 32'd0);
    assign win_final  = win_active && (win_cnt == window_cycles - 32'd1);
    assign in_pkt     = (state == IN_PKT);

    // Per-beat packet tracking; a sop inside a packet aborts the old one and starts anew
    always_comb begin
        state_next  = state;
        len_next    = pkt_len;
        cur_len     = '0;
        framing_set = 1'b0;
        byte_inc    = '0;
        wire_inc    = '0;
        pkt_inc     = '0;
        runt_inc    = '0;
        err_inc     = '0;
        if (accepted) begin
            if (!in_sop && state == IDLE) begin
                framing_set = 1'b1;
            end else begin
                byte_inc = 18'(beat_bytes);
                if (in_sop && state == IN_PKT) begin
                    framing_set = 1'b1;
                    err_inc     = 2'd1;
                end
                cur_len = in_sop ? 16'(beat_bytes) : sat_len(pkt_len, beat_bytes);
                if (in_eop) begin
                    state_next = IDLE;
                    len_next   = '0;
                    wire_inc   = 18'(cur_len) + OVERHEAD;
                    if (in_err) begin
                        err_inc = err_inc + 2'd1;
                    end else begin
                        pkt_inc  = 2'd1;
                        runt_inc = (int'(cur_len) < RUNT_LENGTH) ? 2'd1 : 2'd0;
                    end
                end else begin
                    state_next = IN_PKT;
                    len_next   = cur_len;
                end
            end
        end
    end

    assign pkts_next  = sat32(acc_pkts, pkt_inc);
    assign bytes_next = sat_cnt(acc_bytes, byte_inc);
    assign wire_next  = sat_cnt(acc_wire, wire_inc);
    assign runts_next = sat16(acc_runts, runt_inc);
    assign errs_next  = sat16(acc_errs, err_inc);

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state          <= IDLE;
            pkt_len        <= '0;
            framing_err    <= 1'b0;
            win_cnt        <= '0;
            acc_pkts       <= '0;
            acc_bytes      <= '0;
            acc_wire       <= '0;
            acc_runts      <= '0;
            acc_errs       <= '0;
            win_done       <= 1'b0;
            win_pkts       <= '0;
            win_bytes      <= '0;
            win_wire_bytes <= '0;
            win_runts      <= '0;
            win_err_pkts   <= '0;
        end else begin
            state    <= state_next;
            pkt_len  <= len_next;
            win_done <= 1'b0;
            if (framing_set) framing_err <= 1'b1;
            if (!win_active) begin
                win_cnt   <= '0;
                acc_pkts  <= '0;
                acc_bytes <= '0;
                acc_wire  <= '0;
                acc_runts <= '0;
                acc_errs  <= '0;
            end else if (win_final) begin
                // Snapshot includes this cycle's traffic; next window starts empty
                win_cnt        <= '0;
                win_done       <= 1'b1;
                win_pkts       <= pkts_next;
                win_bytes      <= bytes_next;
                win_wire_bytes <= wire_next;
                win_runts      <= runts_next;
                win_err_pkts   <= errs_next;
                acc_pkts       <= '0;
                acc_bytes      <= '0;
                acc_wire       <= '0;
                acc_runts      <= '0;
                acc_errs       <= '0;
            end else begin
                win_cnt   <= win_cnt + 32'd1;
                acc_pkts  <= pkts_next;
                acc_bytes <= bytes_next;
                acc_wire  <= wire_next;
                acc_runts <= runts_next;
                acc_errs  <= errs_next;
            end
        end
    end

endmodule

// File: tb/tb_acx_ethernet_rx_rate_monitor.sv
// Directed bench for the RX rate monitor: 256-bit stream, narrow byte counters so
// saturation is reachable within a short window.
module tb_acx_ethernet_rx_rate_monitor;

    localparam int CW = 12;
    localparam int MW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid, in_ready, in_sop, in_eop, in_err;
    logic [MW-1:0] in_mod;
    logic          enable, clear;
    logic [31:0]   window_cycles;
    logic          win_done;
    logic [31:0]   win_pkts;
    logic [CW-1:0] win_bytes, win_wire_bytes;
    logic [15:0]   win_runts, win_err_pkts;
    logic          framing_err, in_pkt;

    int checks = 0;
    int errors = 0;

    acx_ethernet_rx_rate_monitor #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_mod(in_mod), .in_err(in_err),
        .enable(enable), .clear(clear), .window_cycles(window_cycles),
        .win_done(win_done), .win_pkts(win_pkts), .win_bytes(win_bytes),
        .win_wire_bytes(win_wire_bytes), .win_runts(win_runts), .win_err_pkts(win_err_pkts),
        .framing_err(framing_err), .in_pkt(in_pkt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic sop, input logic eop, input logic [MW-1:0] mod,
                        input logic err, input logic rdy);
        in_valid = 1'b1; in_ready = rdy; in_sop = sop; in_eop = eop; in_mod = mod; in_err = err;
        tick();
        in_valid = 1'b0; in_ready = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_mod = '0; in_err = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (win_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check(tag, 64'(win_done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 64'(win_done), 0);
        check({tag, "_pkts"}, 64'(win_pkts), 0);
        check({tag, "_bytes"}, 64'(win_bytes), 0);
        check({tag, "_wire"}, 64'(win_wire_bytes), 0);
        check({tag, "_runts"}, 64'(win_runts), 0);
        check({tag, "_errs"}, 64'(win_err_pkts), 0);
        check({tag, "_framing"}, 64'(framing_err), 0);
        check({tag, "_in_pkt"}, 64'(in_pkt), 0);
    endtask

    initial begin
        int dones;
        rstn = 1'b0; in_valid = 1'b0; in_ready = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
        in_mod = '0; in_err = 1'b0; enable = 1'b0; clear = 1'b0; window_cycles = 32'd100;
        #1;
        repeat (3) tick();
        check_all_zero("reset");

        // Two-beat full packet: 64 bytes, 88 on the wire
        rstn = 1'b1; enable = 1'b1;
        send(1, 0, 0, 0, 1);
        check("in_pkt_after_sop", 64'(in_pkt), 1);
        send(0, 1, 0, 0, 1);
        check("in_pkt_after_eop", 64'(in_pkt), 0);
        wait_done("w1_done", 200);
        check("w1_pkts", 64'(win_pkts), 1);
        check("w1_bytes", 64'(win_bytes), 64);
        check("w1_wire", 64'(win_wire_bytes), 88);
        check("w1_runts", 64'(win_runts), 0);
        check("w1_errs", 64'(win_err_pkts), 0);

        // 3-beat mod=5 (69 B) and 2-beat mod=20 runt (52 B)
        send(1, 0, 0, 0, 1);
        check("w1_done_one_cycle", 64'(win_done), 0);
        send(0, 0, 0, 0, 1);
        send(0, 1, 5, 0, 1);
        send(1, 0, 0, 0, 1);
        send(0, 1, 20, 0, 1);
        wait_done("w2_done", 200);
        check("w2_pkts", 64'(win_pkts), 2);
        check("w2_bytes", 64'(win_bytes), 121);
        check("w2_wire", 64'(win_wire_bytes), 169);
        check("w2_runts", 64'(win_runts), 1);
        check("w2_errs", 64'(win_err_pkts), 0);

        // sop, (unaccepted sop), data, sop, eop: one abort, one good packet
        send(1, 0, 0, 0, 1);
        send(1, 0, 0, 0, 0);
        check("noready_in_pkt", 64'(in_pkt), 1);
        check("noready_framing", 64'(framing_err), 0);
        send(0, 0, 0, 0, 1);
        send(1, 0, 0, 0, 1);
        check("abort_framing", 64'(framing_err), 1);
        send(0, 1, 0, 0, 1);
        wait_done("w3_done", 200);
        check("w3_pkts", 64'(win_pkts), 1);
        check("w3_errs", 64'(win_err_pkts), 1);
        check("w3_bytes", 64'(win_bytes), 128);
        check("w3_wire", 64'(win_wire_bytes), 88);

        // Clear, then finish a packet on the exact final cycle of the window
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_all_zero("clear");
        idle(98);
        send(1, 0, 0, 0, 1);
        check("final_not_yet_done", 64'(win_done), 0);
        send(0, 1, 0, 0, 1);
        check("final_done", 64'(win_done), 1);
        check("final_pkts", 64'(win_pkts), 1);
        check("final_bytes", 64'(win_bytes), 64);
        tick();
        check("final_done_drop", 64'(win_done), 0);
        wait_done("w5_done", 200);
        check("w5_pkts", 64'(win_pkts), 0);
        check("w5_bytes", 64'(win_bytes), 0);

        // Non-sop beat while idle is discarded
        send(0, 0, 0, 0, 1);
        check("stray_framing", 64'(framing_err), 1);
        check("stray_in_pkt", 64'(in_pkt), 0);
        wait_done("w6_done", 200);
        check("w6_bytes", 64'(win_bytes), 0);
        check("w6_pkts", 64'(win_pkts), 0);

        // Clear wins over a simultaneous eop
        send(1, 0, 0, 0, 1);
        check("pre_clear_in_pkt", 64'(in_pkt), 1);
        clear = 1'b1;
        send(0, 1, 0, 0, 1);
        clear = 1'b0;
        check_all_zero("clear_eop");

        // Back-to-back 32-byte packets for a 200-cycle window saturate the byte counters
        window_cycles = 32'd200;
        clear = 1'b1;
        in_valid = 1'b1; in_ready = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_mod = '0;
        tick();
        clear = 1'b0;
        wait_done("sat_done", 300);
        in_valid = 1'b0;
        check("sat_pkts", 64'(win_pkts), 200);
        check("sat_runts", 64'(win_runts), 200);
        check("sat_bytes", 64'(win_bytes), 4095);
        check("sat_wire", 64'(win_wire_bytes), 4095);
        check("sat_errs", 64'(win_err_pkts), 0);

        // Disabled: no strobes, snapshots hold
        enable = 1'b0;
        dones = 0;
        for (int i = 0; i < 250; i++) begin
            if (i == 10) begin
                send(1, 1, 0, 0, 1);
            end else begin
                tick();
            end
            if (win_done === 1'b1) dones++;
        end
        check("disabled_dones", 64'(dones), 0);
        check("disabled_hold_bytes", 64'(win_bytes), 4095);
        check("disabled_hold_pkts", 64'(win_pkts), 200);

        // Reset mid-packet discards it; following eop is a stray beat
        enable = 1'b1;
        send(1, 0, 0, 0, 1);
        check("pre_reset_in_pkt", 64'(in_pkt), 1);
        rstn = 1'b0;
        tick();
        check_all_zero("midreset");
        rstn = 1'b1;
        send(0, 1, 0, 0, 1);
        check("post_reset_framing", 64'(framing_err), 1);
        check("post_reset_in_pkt", 64'(in_pkt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
